// File: rtl/bitbang_tx.sv
// ----------------------------------------------------------------------------
// bitbang_tx
//
// Serialises one frame onto a two-wire bitbang link (s_clk/s_data). Each bit
// takes four quarter phases of PHASE_CYCLES clocks:
//   Q0: s_clk=0, s_data=data bit
//   Q1: s_clk=1, s_data=data bit   (receiver samples data on the rising edge)
//   Q2: s_clk=1, s_data=ctrl bit
//   Q3: s_clk=0, s_data=ctrl bit   (receiver samples ctrl on the falling edge)
// s_data only moves at Q0/Q2 starts, so it is settled a full phase before
// every s_clk edge.
//
// Frames:
//   word (tx_op=0): 32 bits, data = tx_data MSB first,
//                   ctrl = 16 zeros then 16'hFAB1 MSB first
//   off  (tx_op=1): 16 bits, data = 0, ctrl = 16'hFAB0 MSB first
//
// Parameters:
//   PHASE_CYCLES   clocks per quarter phase, legal range 2..255
//
// Ports:
//   clk_i            system clock, rising edge
//   resetn_i         asynchronous active-low reset
//   tx_data_i[31:0]  word to send
//   tx_op_i          0 = word frame, 1 = off frame
//   tx_valid_i       request; accepted when tx_valid_i & tx_ready_o
//   tx_ready_o       accept enable
//   s_clk_o          registered serial clock
//   s_data_o         registered serial data
//   busy_o           high while a frame is on the wire
//   done_o           one-cycle pulse when a frame completes
//   active_shadow_o  mirror of the receiver's active flag
//
// Build option:
//   BITBANG_TX_HOLD_BUF_EN  adds a one-entry hold buffer so a new request can
//                           be accepted while a frame is in flight; the
//                           buffered frame starts straight out of DONE.
//
// FSM states:
//   state   | meaning
//   --------+--------------------------------------------------------------
//   IDLE    | lines low, waiting for a request
//   SEND    | frame on the wire; quarter counter, phase and bit index run
//   DONE    | one cycle, lines low, done pulse, shadow flag updated
// ----------------------------------------------------------------------------
module bitbang_tx #(
    parameter int PHASE_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        resetn_i,
    input  logic [31:0] tx_data_i,
    input  logic        tx_op_i,
    input  logic        tx_valid_i,
    output logic        tx_ready_o,
    output logic        s_clk_o,
    output logic        s_data_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        active_shadow_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [7:0]  QLOAD     = 8'(PHASE_CYCLES - 1);
    // Control patterns laid out so that bit index b selects bit [31-b].
    localparam logic [31:0] CTRL_WORD = 32'h0000_FAB1;
    localparam logic [31:0] CTRL_OFF  = 32'hFAB0_0000;

    state_t      state_q, state_d;
    logic [7:0]  qcnt_q, qcnt_d;
    logic [1:0]  phase_q, phase_d;
    logic [4:0]  bit_q, bit_d;
    logic [31:0] data_q, data_d;
    logic        op_q, op_d;

    logic        s_clk_q, s_clk_d;
    logic        s_data_q, s_data_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        active_q, active_d;

    logic        accept;
    logic        start_valid;
    logic [31:0] start_data;
    logic        start_op;
    logic        last_bit;
    logic        load;
    logic [31:0] ctrl_sel;

`ifdef BITBANG_TX_HOLD_BUF_EN
    logic [31:0] buf_data_q, buf_data_d;
    logic        buf_op_q, buf_op_d;
    logic        buf_full_q, buf_full_d;

    assign tx_ready_o  = ~buf_full_q;
    // A buffered frame always has priority over a fresh request; while the
    // buffer is full tx_ready_o is low so the two can never collide.
    assign start_valid = buf_full_q | accept;
    assign start_data  = buf_full_q ? buf_data_q : tx_data_i;
    assign start_op    = buf_full_q ? buf_op_q : tx_op_i;
`else
    assign tx_ready_o  = (state_q == ST_IDLE);
    assign start_valid = accept;
    assign start_data  = tx_data_i;
    assign start_op    = tx_op_i;
`endif

    assign accept   = tx_valid_i & tx_ready_o;
    assign last_bit = op_q ? (bit_q == 5'd15) : (bit_q == 5'd31);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q  <= ST_IDLE;
            qcnt_q   <= '0;
            phase_q  <= '0;
            bit_q    <= '0;
            data_q   <= '0;
            op_q     <= 1'b0;
            s_clk_q  <= 1'b0;
            s_data_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            qcnt_q   <= qcnt_d;
            phase_q  <= phase_d;
            bit_q    <= bit_d;
            data_q   <= data_d;
            op_q     <= op_d;
            s_clk_q  <= s_clk_d;
            s_data_q <= s_data_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            active_q <= active_d;
        end
    end

`ifdef BITBANG_TX_HOLD_BUF_EN
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            buf_data_q <= '0;
            buf_op_q   <= 1'b0;
            buf_full_q <= 1'b0;
        end else begin
            buf_data_q <= buf_data_d;
            buf_op_q   <= buf_op_d;
            buf_full_q <= buf_full_d;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        qcnt_d  = qcnt_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        data_d  = data_q;
        op_d    = op_q;
        load    = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_valid) begin
                    load = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (qcnt_q != 8'd0) begin
                    qcnt_d = qcnt_q - 8'd1;
                end else begin
                    qcnt_d = QLOAD;
                    if (phase_q == 2'd3) begin
                        phase_d = 2'd0;
                        if (last_bit) begin
                            state_d = ST_DONE;
                            bit_d   = 5'd0;
                        end else begin
                            bit_d = bit_q + 5'd1;
                        end
                    end else begin
                        phase_d = phase_q + 2'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load) begin
            state_d = ST_SEND;
            qcnt_d  = QLOAD;
            phase_d = 2'd0;
            bit_d   = 5'd0;
            data_d  = start_data;
            op_d    = start_op;
        end
    end

`ifdef BITBANG_TX_HOLD_BUF_EN
    always_comb begin
        buf_data_d = buf_data_q;
        buf_op_d   = buf_op_q;
        buf_full_d = buf_full_q;
        if (load && buf_full_q) begin
            buf_full_d = 1'b0;
        end
        // Requests in IDLE/DONE with an empty buffer go straight to SEND;
        // only a request arriving mid-frame is parked here.
        if (accept && (state_q == ST_SEND)) begin
            buf_data_d = tx_data_i;
            buf_op_d   = tx_op_i;
            buf_full_d = 1'b1;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Output logic: decoded from the next state so the line registers show
    // the first frame values on the cycle right after accept.
    // ------------------------------------------------------------------
    always_comb begin
        s_clk_d  = 1'b0;
        s_data_d = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        active_d = active_q;
        ctrl_sel = op_d ? CTRL_OFF : CTRL_WORD;

        case (state_d)
            ST_SEND: begin
                busy_d   = 1'b1;
                s_clk_d  = phase_d[0] ^ phase_d[1];
                s_data_d = phase_d[1] ? ctrl_sel[~bit_d]
                                      : (data_d[~bit_d] & ~op_d);
            end
            ST_DONE: begin
                done_d   = 1'b1;
                active_d = ~op_d;
            end
            default: ;
        endcase
    end

    assign s_clk_o         = s_clk_q;
    assign s_data_o        = s_data_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign active_shadow_o = active_q;

endmodule
